// File: rtl/fetch_pkg.sv
// Shared fetch types: data width, fetch FSM state and instruction-queue entry.
package fetch_pkg;

    localparam int I = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [I-1:0] pc;
        logic [I-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/ack bus between fetch_unit (master) and the memory (slave).
interface fetch_if #(
    parameter int W = fetch_pkg::I
) ();
    logic         imem_req;
    logic [W-1:0] imem_addr;
    logic         imem_ack;
    logic [W-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry {pc, instr} queue with push/pop/clear; head is always slot 0.
// Latency: a push into an empty queue appears at the head the next cycle.
// Backpressure: caller never pushes when full; an empty queue keeps the last head value.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t pushEntry,
    input  logic         pop,
    input  logic         clear,
    output fetch_entry_t head,
    output logic [1:0]   count
);

    fetch_entry_t tail;

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else if (clear) begin
            // Entries are left in place so the head outputs hold their last value.
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= pushEntry;
                    else               tail <= pushEntry;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) head <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        head <= tail;
                        tail <= pushEntry;
                    end else begin
                        head <= pushEntry;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencer + imem request FSM feeding a 2-entry queue; FETCH_PERF_EN adds perf counters.
// Latency: ack on edge k gives InstrValidF=1 in cycle k+1.
// Backpressure: StallF holds the head; no request is issued while the queue is full.
module fetch_unit #(
    parameter int           I        = 32,
    parameter logic [I-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_if.master      imem,
    input  logic         StallF,
    input  logic         BranchTakenE,
    input  logic [I-1:0] BranchTargetE,
    output logic [I-1:0] InstrF,
    output logic         InstrValidF,
    output logic [I-1:0] PCF,
    output logic [I-1:0] PCPlus4F
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_discarded
`endif
);
    import fetch_pkg::*;

    fetch_state_t state;
    logic [I-1:0] fetchPc;
    logic [I-1:0] pcInc;
    logic [I-1:0] target;
    fetch_entry_t head;
    fetch_entry_t pushEntry;
    logic [1:0]   count;
    logic [1:0]   countNext;
    logic         ackHit;
    logic         push;
    logic         pop;
    logic         clear;

    assign target    = BranchTargetE & ~(I'(3));
    assign pcInc     = fetchPc + I'(4);
    assign ackHit    = imem.imem_req && imem.imem_ack;
    assign clear     = BranchTakenE;
    assign pop       = InstrValidF && !StallF && !BranchTakenE;
    assign push      = (state == WAIT) && ackHit && !BranchTakenE;
    assign countNext = clear ? 2'd0 : count + {1'b0, push} - {1'b0, pop};

    assign pushEntry.pc    = fetchPc;
    assign pushEntry.instr = imem.imem_rdata;

    fetch_queue u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pushEntry (pushEntry),
        .pop       (pop),
        .clear     (clear),
        .head      (head),
        .count     (count)
    );

    assign InstrValidF = (count != 2'd0);
    assign InstrF      = head.instr;
    assign PCF         = head.pc;
    assign PCPlus4F    = head.pc + I'(4);

    // imem_addr tracks fetchPc except in DRAIN, where it must stay on the abandoned address.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            fetchPc        <= RESET_PC;
            imem.imem_req  <= 1'b0;
            imem.imem_addr <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (BranchTakenE) begin
                        state          <= WAIT;
                        fetchPc        <= target;
                        imem.imem_req  <= 1'b1;
                        imem.imem_addr <= target;
                    end else if (countNext < 2'd2) begin
                        state          <= WAIT;
                        imem.imem_req  <= 1'b1;
                        imem.imem_addr <= fetchPc;
                    end
                end
                WAIT: begin
                    if (BranchTakenE) begin
                        fetchPc <= target;
                        if (ackHit) imem.imem_addr <= target;
                        else        state          <= DRAIN;
                    end else if (ackHit) begin
                        fetchPc        <= pcInc;
                        imem.imem_addr <= pcInc;
                        if (countNext == 2'd2) begin
                            state         <= IDLE;
                            imem.imem_req <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (BranchTakenE) fetchPc <= target;
                    if (ackHit) begin
                        state          <= WAIT;
                        imem.imem_addr <= BranchTakenE ? target : fetchPc;
                    end
                end
                default: begin
                    state         <= IDLE;
                    imem.imem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    // Discards are queue entries lost to a redirect plus responses thrown away in DRAIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched   <= 32'd0;
            perf_discarded <= 32'd0;
        end else begin
            if (push) perf_fetched <= perf_fetched + 32'd1;
            perf_discarded <= perf_discarded
                            + (clear ? 32'(count) : 32'd0)
                            + (((state == DRAIN) && ackHit) ? 32'd1 : 32'd0);
        end
    end
`endif

endmodule
